reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_pkg.sv | 22 ++
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/reset_cause_latch.sv | 45 ++++
 rtl/reset_sequencer.sv | 106 ++++++++++
 tb/tb_reset_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer slice.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Position of the hard-reset flag inside the cause vector.
    localparam int unsigned CAUSE_RESET = 0;

    // Width of the shared stretch/gap counter; one spare bit above the
    // largest terminal count.
    function automatic int unsigned cnt_width(input int unsigned stretch,
                                              input int unsigned gap);
        int unsigned m;
        m = (stretch > gap) ? stretch : gap;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/mask/cause/reset-output bundle between the pin wrapper and the sequencer.
interface reset_sequencer_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_OUT = 2
);
    logic [NUM_SRC-1:0] src_req;
    logic [NUM_SRC-1:0] src_mask;
    logic               cause_clr;
    logic [NUM_OUT-1:0] rst_out;
    logic               busy;
    logic [NUM_SRC:0]   cause;

    modport master (
        output src_req, src_mask, cause_clr,
        input  rst_out, busy, cause
    );

    modport slave (
        input  src_req, src_mask, cause_clr,
        output rst_out, busy, cause
    );
endinterface

// File: rtl/reset_cause_latch.sv
// Masks the request sources, reduces them to one request and keeps the
// sticky record of which source caused the last reset.
module reset_cause_latch import reset_seq_pkg::*; #(
    parameter int unsigned NUM_SRC = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_req_i,
    input  logic [NUM_SRC-1:0] src_mask_i,
    input  logic               cause_clr_i,
    output logic               req_o,
    output logic [NUM_SRC:0]   cause_o
);

    logic [NUM_SRC-1:0] hit;
    logic [NUM_SRC:0]   cause_d;
    logic [NUM_SRC:0]   cause_q;

    assign hit   = src_req_i & ~src_mask_i;
    assign req_o = |hit;

    // New cause bits win over a simultaneous clear; the clear still drops older bits.
    always_comb begin
        cause_d = cause_q;
        if (req_o) begin
            cause_d = cause_clr_i ? '0 : cause_q;
            cause_d[NUM_SRC:1] = cause_d[NUM_SRC:1] | hit;
        end else if (cause_clr_i) begin
            cause_d = '0;
        end
    end

    // Cause register; a hard reset leaves only its own flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q              <= '0;
            cause_q[CAUSE_RESET] <= 1'b1;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign cause_o = cause_q;

endmodule

// File: rtl/reset_sequencer.sv
// Merges hard reset and request sources, stretches the reset and releases
// the downstream domains one by one, lowest index first.
module reset_sequencer import reset_seq_pkg::*; #(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned NUM_OUT        = 2,
    parameter int unsigned STRETCH_CYCLES = 8,
    parameter int unsigned STAGE_GAP      = 2
) (
    input  logic                clk,
    input  logic                reset,
    reset_sequencer_if.slave    bus
);

    localparam int unsigned CNT_W   = cnt_width(STRETCH_CYCLES, STAGE_GAP);
    localparam int unsigned STAGE_W = $clog2(NUM_OUT + 1);

    logic               req;
    logic [NUM_SRC:0]   cause;

    state_t             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [STAGE_W-1:0] stage_d, stage_q;
    logic [NUM_OUT-1:0] rst_out_d, rst_out_q;

    reset_cause_latch #(
        .NUM_SRC (NUM_SRC)
    ) u_cause (
        .clk         (clk),
        .reset       (reset),
        .src_req_i   (bus.src_req),
        .src_mask_i  (bus.src_mask),
        .cause_clr_i (bus.cause_clr),
        .req_o       (req),
        .cause_o     (cause)
    );

    // Next-state logic: a request restarts the sequence from any state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        rst_out_d = rst_out_q;
        if (req) begin
            state_d   = HOLD;
            cnt_d     = '0;
            rst_out_d = '1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = '0;
                        stage_d      = STAGE_W'(1);
                        state_d      = (NUM_OUT == 1) ? IDLE : RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        // Loop over outputs so the variable stage index never selects out of range.
                        for (int unsigned k = 0; k < NUM_OUT; k++) begin
                            if (stage_q == STAGE_W'(k)) begin
                                rst_out_d[k] = 1'b0;
                            end
                        end
                        stage_d = stage_q + STAGE_W'(1);
                        cnt_d   = '0;
                        if (stage_q == STAGE_W'(NUM_OUT - 1)) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                IDLE: begin
                    rst_out_d = '0;
                end
                default: begin
                    state_d   = IDLE;
                    rst_out_d = '0;
                end
            endcase
        end
    end

    // State, counter and reset-output registers; hard reset restarts the hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            stage_q   <= '0;
            rst_out_q <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign bus.rst_out = rst_out_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.cause   = cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a time-since-trigger model.
module tb_reset_sequencer;

    localparam int unsigned NSRC = 2;
    localparam int unsigned NOUT = 3;
    localparam int unsigned S    = 8;
    localparam int unsigned G    = 2;

    logic clk;
    logic reset;

    reset_sequencer_if #(.NUM_SRC(NSRC), .NUM_OUT(NOUT)) bus ();

    reset_sequencer #(
        .NUM_SRC        (NSRC),
        .NUM_OUT        (NOUT),
        .STRETCH_CYCLES (S),
        .STAGE_GAP      (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Outputs depend only on how many edges have passed since the last edge
    // that sampled reset or an unmasked request.
    int                cyc        = 0;
    int                last_trig  = 0;
    bit                model_ok   = 1'b0;
    logic [NSRC:0]     m_cause    = '0;
    logic [NSRC-1:0]   hits;

    assign hits = bus.src_req & ~bus.src_mask;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset || (|hits)) last_trig <= cyc + 1;
        if (reset) begin
            m_cause  <= 1;
            model_ok <= 1'b1;
        end else if (|hits) begin
            m_cause <= (bus.cause_clr ? '0 : m_cause) | {hits, 1'b0};
        end else if (bus.cause_clr) begin
            m_cause <= '0;
        end
    end

    function automatic logic [NOUT-1:0] exp_rst(input int elapsed);
        logic [NOUT-1:0] r;
        for (int k = 0; k < NOUT; k++) r[k] = (elapsed < int'(S + k * G));
        return r;
    endfunction

    always @(negedge clk) begin
        if (model_ok) begin
            check("model rst_out", 32'(bus.rst_out), 32'(exp_rst(cyc - last_trig)));
            check("model busy", 32'(bus.busy), 32'((cyc - last_trig) < int'(S + (NOUT - 1) * G)));
            check("model cause", 32'(bus.cause), 32'(m_cause));
        end
    end

    // ---------------- directed helpers ----------------
    // Called at the negedge right after the triggering edge; checks the
    // hand-computed 8/10/12 release schedule.
    task automatic sched(input string tag);
        check({tag, " rst@0"}, 32'(bus.rst_out), 32'h7);
        check({tag, " busy@0"}, 32'(bus.busy), 32'h1);
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            case (e)
                7:       check({tag, " rst@7"},  32'(bus.rst_out), 32'h7);
                8:       check({tag, " rst@8"},  32'(bus.rst_out), 32'h6);
                9:       check({tag, " rst@9"},  32'(bus.rst_out), 32'h6);
                10:      check({tag, " rst@10"}, 32'(bus.rst_out), 32'h4);
                11: begin
                         check({tag, " rst@11"}, 32'(bus.rst_out), 32'h4);
                         check({tag, " busy@11"}, 32'(bus.busy), 32'h1);
                    end
                12: begin
                         check({tag, " rst@12"}, 32'(bus.rst_out), 32'h0);
                         check({tag, " busy@12"}, 32'(bus.busy), 32'h0);
                    end
                default: ;
            endcase
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b1;
        bus.src_req   = '0;
        bus.src_mask  = '0;
        bus.cause_clr = 1'b0;

        // 1: reset held for three edges
        repeat (3) @(negedge clk);
        check("t1 rst during reset", 32'(bus.rst_out), 32'h7);
        check("t1 cause during reset", 32'(bus.cause), 32'h1);
        reset = 1'b0;
        sched("t1");

        // 2: clear cause, then one-cycle request on source 1
        bus.cause_clr = 1'b1;
        @(negedge clk);
        bus.cause_clr = 1'b0;
        check("t2 cause cleared", 32'(bus.cause), 32'h0);
        bus.src_req = 2'b10;
        @(negedge clk);
        bus.src_req = '0;
        check("t2 cause", 32'(bus.cause), 32'h4);
        sched("t2");

        // 3: masked source while idle
        bus.src_mask = 2'b01;
        bus.src_req  = 2'b01;
        @(negedge clk);
        bus.src_req = '0;
        check("t3 rst", 32'(bus.rst_out), 32'h0);
        check("t3 busy", 32'(bus.busy), 32'h0);
        check("t3 cause", 32'(bus.cause), 32'h4);
        bus.src_mask = '0;

        // 4: request one cycle after rst_out[0] falls
        bus.src_req = 2'b10;
        @(negedge clk);
        bus.src_req = '0;
        repeat (8) @(negedge clk);
        check("t4 rst before", 32'(bus.rst_out), 32'h6);
        bus.src_req = 2'b01;
        @(negedge clk);
        bus.src_req = '0;
        check("t4 cause", 32'(bus.cause), 32'h6);
        sched("t4");

        // 5: request held for five edges
        bus.src_req = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5 rst held", 32'(bus.rst_out), 32'h7);
        end
        bus.src_req = '0;
        sched("t5");

        // 6: clear and request on the same edge
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6 cause after reset", 32'(bus.cause), 32'h1);
        bus.cause_clr = 1'b1;
        bus.src_req   = 2'b01;
        @(negedge clk);
        bus.cause_clr = 1'b0;
        bus.src_req   = '0;
        check("t6 cause tie", 32'(bus.cause), 32'h2);
        sched("t6");

        // randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 249) == 0);
            bus.src_req   = ($urandom_range(0, 17) == 0) ? NSRC'($urandom) : '0;
            bus.src_mask  = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
            bus.cause_clr = ($urandom_range(0, 14) == 0);
            @(negedge clk);
        end
        reset         = 1'b0;
        bus.src_req   = '0;
        bus.src_mask  = '0;
        bus.cause_clr = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
